// File: rtl/filterbank_pkg.sv
// ============================================================================
// filterbank_pkg : shared defaults and helpers for the streaming filterbank
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package filterbank_pkg;

    localparam int DEF_INPUT_LEN   = 129;
    localparam int DEF_NUM_FILTERS = 32;
    localparam int DEF_COEF_BW     = 16;
    localparam int DEF_BIN_BW      = 8;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_ceil(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Default bank boundaries: filter f ends on bin 4*(f+1).
    function automatic logic [DEF_NUM_FILTERS*DEF_BIN_BW-1:0] def_boundary();
        logic [DEF_NUM_FILTERS*DEF_BIN_BW-1:0] v;
        v = '0;
        for (int f = 0; f < DEF_NUM_FILTERS; f++) begin
            v[f*DEF_BIN_BW +: DEF_BIN_BW] = DEF_BIN_BW'((f + 1) * 4);
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/filterbank_lane.sv
// ============================================================================
// filterbank_lane : coefficient ROM, multiplier and accumulator for one lane
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module filterbank_lane
    import filterbank_pkg::*;
#(
    parameter int I_BW      = 32,
    parameter int COEF_BW   = DEF_COEF_BW,
    parameter int BIN_BW    = DEF_BIN_BW,
    parameter int ACC_BW    = I_BW + COEF_BW + BIN_BW,
    parameter int INPUT_LEN = DEF_INPUT_LEN,
    parameter logic [INPUT_LEN*COEF_BW-1:0] COEF_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_add,
    input  logic              i_close,
    input  logic [BIN_BW-1:0] i_bin,
    input  logic [I_BW-1:0]   i_data,
    output logic [ACC_BW-1:0] o_result
);

    localparam int PROD_BW = I_BW + COEF_BW;

    logic [COEF_BW-1:0] w_coef;
    logic [PROD_BW-1:0] w_prod;
    logic [ACC_BW-1:0]  r_acc;

    // ROM contents arrive as a parameter so the block elaborates standalone.
    always_comb begin
        w_coef = '0;
        for (int i = 0; i < INPUT_LEN; i++) begin
            if (i_bin == BIN_BW'(i)) w_coef = COEF_INIT[i*COEF_BW +: COEF_BW];
        end
    end

    assign w_prod   = PROD_BW'(i_data) * PROD_BW'(w_coef);
    assign o_result = r_acc + ACC_BW'(w_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_add) begin
            r_acc <= i_close ? '0 : o_result;
        end
    end

endmodule

`default_nettype wire

// File: rtl/filterbank_stream.sv
// ============================================================================
// filterbank_stream : two-lane streaming triangular filterbank with saturation
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module filterbank_stream
    import filterbank_pkg::*;
#(
    parameter int I_BW        = 32,
    parameter int O_BW        = 32,
    parameter int COEF_BW     = DEF_COEF_BW,
    parameter int INPUT_LEN   = DEF_INPUT_LEN,
    parameter int NUM_FILTERS = DEF_NUM_FILTERS,
    parameter int BIN_BW      = DEF_BIN_BW,
    parameter int ACC_BW      = I_BW + COEF_BW + BIN_BW,
    parameter logic [INPUT_LEN*COEF_BW-1:0] COEF_EVEN_INIT =
        {INPUT_LEN{{1'b1, {(COEF_BW-1){1'b0}}}}},
    parameter logic [INPUT_LEN*COEF_BW-1:0] COEF_ODD_INIT =
        {INPUT_LEN{{1'b1, {(COEF_BW-1){1'b0}}}}},
    parameter logic [NUM_FILTERS*BIN_BW-1:0] BOUNDARY_INIT = def_boundary()
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 en_i,
    input  logic [I_BW-1:0]                      data_i,
    input  logic                                 valid_i,
    input  logic                                 last_i,
    output logic [O_BW-1:0]                      data_o,
    output logic [clog2_ceil(NUM_FILTERS)-1:0]   idx_o,
    output logic                                 valid_o,
    output logic                                 last_o,
    output logic                                 sat_o,
    output logic                                 frame_err_o
);

    localparam int IDX_BW = clog2_ceil(NUM_FILTERS);
    localparam int F_BW   = IDX_BW + 1;

    logic [BIN_BW-1:0] r_b;
    logic [F_BW-1:0]   r_f;
    logic [IDX_BW-1:0] w_fi;
    logic [BIN_BW-1:0] w_bound;
    logic              w_acc, w_f_ok, w_bin_last, w_close, w_end, w_err, w_clr;
    logic [ACC_BW-1:0] w_res_even, w_res_odd, w_result, w_scaled;
    logic              w_sat;
    logic [O_BW-1:0]   w_data;

    assign w_acc      = valid_i & en_i;
    assign w_fi       = r_f[IDX_BW-1:0];
    assign w_f_ok     = r_f < F_BW'(NUM_FILTERS);
    assign w_bin_last = r_b == BIN_BW'(INPUT_LEN - 1);

    always_comb begin
        w_bound = '0;
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (w_fi == IDX_BW'(i)) w_bound = BOUNDARY_INIT[i*BIN_BW +: BIN_BW];
        end
    end

    assign w_close = w_acc & w_f_ok & (r_b == w_bound);
    assign w_end   = w_acc & (last_i | w_bin_last);
    assign w_err   = w_acc & (last_i ^ w_bin_last);
    assign w_clr   = ~en_i | w_end;

    filterbank_lane #(
        .I_BW(I_BW), .COEF_BW(COEF_BW), .BIN_BW(BIN_BW), .ACC_BW(ACC_BW),
        .INPUT_LEN(INPUT_LEN), .COEF_INIT(COEF_EVEN_INIT)
    ) u_lane_even (
        .clk(clk_i), .rst(rst_i), .i_clr(w_clr), .i_add(w_acc),
        .i_close(w_close & ~w_fi[0]), .i_bin(r_b), .i_data(data_i),
        .o_result(w_res_even)
    );

    filterbank_lane #(
        .I_BW(I_BW), .COEF_BW(COEF_BW), .BIN_BW(BIN_BW), .ACC_BW(ACC_BW),
        .INPUT_LEN(INPUT_LEN), .COEF_INIT(COEF_ODD_INIT)
    ) u_lane_odd (
        .clk(clk_i), .rst(rst_i), .i_clr(w_clr), .i_add(w_acc),
        .i_close(w_close & w_fi[0]), .i_bin(r_b), .i_data(data_i),
        .o_result(w_res_odd)
    );

    assign w_result = w_fi[0] ? w_res_odd : w_res_even;
    assign w_scaled = w_result >> COEF_BW;
    assign w_sat    = (w_scaled >> O_BW) != '0;
    assign w_data   = w_sat ? '1 : w_scaled[O_BW-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_b <= '0;
            r_f <= '0;
        end else if (!en_i || w_end) begin
            r_b <= '0;
            r_f <= '0;
        end else if (w_acc) begin
            r_b <= r_b + 1'b1;
            r_f <= r_f + F_BW'(w_close);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o      <= '0;
            idx_o       <= '0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            sat_o       <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= w_close;
            data_o      <= w_close ? w_data : '0;
            idx_o       <= w_close ? w_fi : '0;
            sat_o       <= w_close & w_sat;
            last_o      <= w_close & (w_fi == IDX_BW'(NUM_FILTERS - 1));
            frame_err_o <= w_err;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_filterbank_stream.sv
// ============================================================================
// tb_filterbank_stream : directed vector bench for filterbank_stream
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_filterbank_stream;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        last_i;

    logic [31:0] data_o;
    logic [1:0]  idx_o;
    logic        valid_o, last_o, sat_o, frame_err_o;

    logic [15:0] s_data_o;
    logic [1:0]  s_idx_o;
    logic        s_valid_o, s_last_o, s_sat_o, s_frame_err_o;

    always #5 clk_i = ~clk_i;

    filterbank_stream #(
        .I_BW(32), .O_BW(32), .COEF_BW(16), .INPUT_LEN(8), .NUM_FILTERS(4), .BIN_BW(8),
        .COEF_EVEN_INIT({8{16'h8000}}), .COEF_ODD_INIT({8{16'h8000}}),
        .BOUNDARY_INIT(32'h07050301)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i),
        .valid_i(valid_i), .last_i(last_i), .data_o(data_o), .idx_o(idx_o),
        .valid_o(valid_o), .last_o(last_o), .sat_o(sat_o), .frame_err_o(frame_err_o)
    );

    filterbank_stream #(
        .I_BW(32), .O_BW(16), .COEF_BW(16), .INPUT_LEN(8), .NUM_FILTERS(4), .BIN_BW(8),
        .COEF_EVEN_INIT({8{16'hFFFF}}), .COEF_ODD_INIT({8{16'hFFFF}}),
        .BOUNDARY_INIT(32'h07050301)
    ) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i),
        .valid_i(valid_i), .last_i(last_i), .data_o(s_data_o), .idx_o(s_idx_o),
        .valid_o(s_valid_o), .last_o(s_last_o), .sat_o(s_sat_o), .frame_err_o(s_frame_err_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        valid, last, en;
        logic        ev;
        logic [1:0]  eidx;
        logic [31:0] edata;
        logic        elast, esat, eerr;
    } vec_t;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] d, input logic v, input logic l,
                                input logic e, input logic ev, input logic [1:0] ei,
                                input logic [31:0] ed, input logic el, input logic es,
                                input logic ee);
        vec_t t;
        t.data = d; t.valid = v; t.last = l; t.en = e;
        t.ev = ev; t.eidx = ei; t.edata = ed; t.elast = el; t.esat = es; t.eerr = ee;
        return t;
    endfunction

    function automatic vec_t idle();
        return mk(32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    // Fresh-frame expectation for data 2, coef 0.5, boundaries {1,3,5,7}.
    // Filter 0 spans bins 0..1 (=2); each later filter overlaps its
    // predecessor and integrates 4 bins (=4).
    function automatic vec_t smp(input int bin, input logic l, input logic err);
        logic v;
        v = (bin % 2) == 1;
        return mk(32'd2, 1'b1, l, 1'b1, v, v ? 2'(bin / 2) : 2'd0,
                  v ? ((bin == 1) ? 32'd2 : 32'd4) : 32'd0, bin == 7, 1'b0, err);
    endfunction

    task automatic apply(input vec_t t, input string tag);
        en_i = t.en; valid_i = t.valid; last_i = t.last; data_i = t.data;
        @(posedge clk_i);
        #1;
        chk({tag, ".valid"}, 64'(valid_o), 64'(t.ev));
        chk({tag, ".idx"},   64'(idx_o),   64'(t.eidx));
        chk({tag, ".data"},  64'(data_o),  64'(t.edata));
        chk({tag, ".last"},  64'(last_o),  64'(t.elast));
        chk({tag, ".sat"},   64'(sat_o),   64'(t.esat));
        chk({tag, ".err"},   64'(frame_err_o), 64'(t.eerr));
    endtask

    task automatic run_frame(input string tag);
        for (int b = 0; b < 8; b++) apply(smp(b, b == 7, 1'b0), $sformatf("%s.b%0d", tag, b));
    endtask

    initial begin
        rst_i = 1'b1; en_i = 1'b1; valid_i = 1'b0; last_i = 1'b0; data_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.valid", 64'(valid_o), 64'd0);
        chk("rst.data",  64'(data_o),  64'd0);
        chk("rst.err",   64'(frame_err_o), 64'd0);
        rst_i = 1'b0;

        vecs.push_back(idle());
        for (int b = 0; b < 8; b++) vecs.push_back(smp(b, b == 7, 1'b0));
        // short frame: last on bin 4
        for (int b = 0; b < 5; b++) vecs.push_back(smp(b, b == 4, b == 4));
        for (int b = 0; b < 8; b++) vecs.push_back(smp(b, b == 7, 1'b0));
        // long frame: no last on bin 7, close still emitted
        for (int b = 0; b < 8; b++) vecs.push_back(smp(b, 1'b0, b == 7));
        for (int b = 0; b < 8; b++) vecs.push_back(smp(b, b == 7, 1'b0));
        vecs.push_back(mk(32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0));

        foreach (vecs[n]) apply(vecs[n], $sformatf("v%0d", n));

        // valid gaps: three idle cycles after each sample
        for (int b = 0; b < 8; b++) begin
            apply(smp(b, b == 7, 1'b0), $sformatf("gap.b%0d", b));
            for (int g = 0; g < 3; g++) apply(idle(), $sformatf("gap.b%0d.i%0d", b, g));
        end

        // saturation on the 16-bit-output instance
        for (int b = 0; b < 8; b++) begin
            en_i = 1'b1; valid_i = 1'b1; last_i = (b == 7); data_i = 32'hFFFF_FFFF;
            @(posedge clk_i);
            #1;
            chk($sformatf("sat.b%0d.valid", b), 64'(s_valid_o), 64'(b % 2));
            chk($sformatf("sat.b%0d.data", b), 64'(s_data_o), (b % 2) ? 64'hFFFF : 64'd0);
            chk($sformatf("sat.b%0d.sat", b), 64'(s_sat_o), 64'(b % 2));
            chk($sformatf("sat.b%0d.idx", b), 64'(s_idx_o), (b % 2) ? 64'(b / 2) : 64'd0);
        end
        valid_i = 1'b0; last_i = 1'b0;
        apply(idle(), "sat.tail");

        // asynchronous reset mid-frame, right after filter 1 is emitted
        for (int b = 0; b < 4; b++) apply(smp(b, 1'b0, 1'b0), $sformatf("arst.b%0d", b));
        valid_i = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        chk("arst.valid", 64'(valid_o), 64'd0);
        chk("arst.data",  64'(data_o),  64'd0);
        chk("arst.idx",   64'(idx_o),   64'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        run_frame("arst.post");

        // enable dropped for one cycle where filter 1 would close
        for (int b = 0; b < 3; b++) apply(smp(b, 1'b0, 1'b0), $sformatf("en.b%0d", b));
        apply(mk(32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0), "en.off");
        run_frame("en.post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
